// File: rtl/pwm_capture.sv
// pwm_capture: measures period and high time of an asynchronous PWM input
// and emits one sample per full cycle on a single-slot valid/ready stream.
// Optional idle-line timeout sample: define PWM_CAPTURE_TIMEOUT_EN.
module pwm_capture #(
  parameter int unsigned CNT_WIDTH      = 32,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                 ACLK,
  input  logic                 ARESET,
  input  logic                 pwm_in,
  input  logic                 en,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [CNT_WIDTH-1:0] m_period,
  output logic [CNT_WIDTH-1:0] m_high,
  output logic                 m_ovf,
  output logic                 m_timeout,
  output logic                 lost,
  input  logic                 clr_lost
);

  typedef enum logic [1:0] {IDLE, ARM, HIGH, LOW} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  // Reject synchronizer depths outside the supported range at elaboration
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || TIMEOUT_CYCLES == 0) begin : g_bad_param
    $error("pwm_capture: illegal parameter value");
  end

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic                   hist_q;
  logic                   rise_q, fall_q;
  logic [CNT_WIDTH-1:0]   cnt_q;
  logic [CNT_WIDTH-1:0]   high_q;
  logic                   ovf_q;
  logic                   emit_c;
  logic                   to_fire_c;
  logic                   load_c;
  logic                   drop_c;
  logic                   restart_c;
  logic                   run_c;

  assign sync = sync_q[SYNC_STAGES-1];

  // Synchronizer, history flop and registered edge pulses
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      sync_q <= '0;
      hist_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      hist_q <= sync;
      rise_q <= sync & ~hist_q;
      fall_q <= ~sync & hist_q;
    end
  end

`ifdef PWM_CAPTURE_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] to_cnt_q;
  logic            to_armed_q;
  logic            to_hit_c;

  assign to_hit_c = to_armed_q && (state_q != IDLE) && !rise_q && !fall_q &&
                    (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  // Idle-line counter; re-armed by any edge, disarmed once it has fired
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      to_cnt_q   <= '0;
      to_armed_q <= 1'b1;
    end else if (!en || state_q == IDLE || rise_q || fall_q) begin
      to_cnt_q   <= '0;
      to_armed_q <= 1'b1;
    end else if (to_hit_c) begin
      to_cnt_q   <= '0;
      to_armed_q <= 1'b0;
    end else if (to_armed_q) begin
      to_cnt_q   <= to_cnt_q + TO_W'(1);
    end
  end
`endif

  // FSM state register
  always_ff @(posedge ACLK) begin
    if (ARESET) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state and sample emit decision
  always_comb begin
    state_d   = state_q;
    emit_c    = 1'b0;
    to_fire_c = 1'b0;
    if (!en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = ARM;
        ARM:     if (rise_q) state_d = HIGH;
        HIGH:    if (fall_q) state_d = LOW;
        LOW:     if (rise_q) begin
                   state_d = HIGH;
                   emit_c  = 1'b1;
                 end
        default: state_d = IDLE;
      endcase
`ifdef PWM_CAPTURE_TIMEOUT_EN
      if (to_hit_c) begin
        state_d   = ARM;
        emit_c    = 1'b1;
        to_fire_c = 1'b1;
      end
`endif
    end
  end

  assign restart_c = en && rise_q && (state_q == ARM || state_q == LOW);
  assign run_c     = en && (state_q == HIGH || state_q == LOW);

  // Saturating cycle counter and captured high time
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      cnt_q  <= '0;
      high_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (restart_c) begin
        cnt_q <= CNT_WIDTH'(1);
        ovf_q <= 1'b0;
      end else if (run_c) begin
        if (cnt_q == CNT_MAX) ovf_q <= 1'b1;
        else                  cnt_q <= cnt_q + CNT_WIDTH'(1);
      end
      if (en && state_q == HIGH && fall_q) high_q <= cnt_q;
    end
  end

  assign load_c = emit_c && (!m_valid || m_ready);
  assign drop_c = emit_c && m_valid && !m_ready;

  // Single output slot with drop-on-full and sticky lost flag
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      m_valid  <= 1'b0;
      m_period <= '0;
      m_high   <= '0;
      m_ovf    <= 1'b0;
      lost     <= 1'b0;
    end else begin
      if (load_c) begin
        m_valid  <= 1'b1;
        m_period <= to_fire_c ? '0 : cnt_q;
        m_high   <= to_fire_c ? {CNT_WIDTH{sync}} : high_q;
        m_ovf    <= to_fire_c ? 1'b0 : ovf_q;
      end else if (m_ready) begin
        m_valid  <= 1'b0;
      end
      if (drop_c)        lost <= 1'b1;
      else if (clr_lost) lost <= 1'b0;
    end
  end

`ifdef PWM_CAPTURE_TIMEOUT_EN
  // Timeout marker travels with the sample it belongs to
  always_ff @(posedge ACLK) begin
    if (ARESET)      m_timeout <= 1'b0;
    else if (load_c) m_timeout <= to_fire_c;
  end
`else
  assign m_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: default 32-bit instance plus an 8-bit
// instance for saturation; timeout instance only with PWM_CAPTURE_TIMEOUT_EN.
module tb_pwm_capture;

  typedef struct {
    logic [31:0] period;
    logic [31:0] high;
    logic        ovf;
    logic        tmo;
  } samp_t;

  logic ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  logic        ARESET, pwm_in, en, m_ready, clr_lost;
  logic        m_valid, m_ovf, m_timeout, lost;
  logic [31:0] m_period, m_high;
  logic        v8, o8, t8, l8;
  logic [7:0]  p8, h8;

  int checks = 0;
  int errors = 0;

  samp_t q[$];
  samp_t q8[$];
  logic  hold_viol = 1'b0;
  logic  pv = 1'b0, pr = 1'b0, po = 1'b0;
  logic [31:0] pp = '0, ph = '0;

  pwm_capture dut (
    .ACLK(ACLK), .ARESET(ARESET), .pwm_in(pwm_in), .en(en),
    .m_valid(m_valid), .m_ready(m_ready), .m_period(m_period), .m_high(m_high),
    .m_ovf(m_ovf), .m_timeout(m_timeout), .lost(lost), .clr_lost(clr_lost)
  );

  pwm_capture #(.CNT_WIDTH(8), .SYNC_STAGES(2), .TIMEOUT_CYCLES(1024)) dut8 (
    .ACLK(ACLK), .ARESET(ARESET), .pwm_in(pwm_in), .en(en),
    .m_valid(v8), .m_ready(m_ready), .m_period(p8), .m_high(h8),
    .m_ovf(o8), .m_timeout(t8), .lost(l8), .clr_lost(clr_lost)
  );

`ifdef PWM_CAPTURE_TIMEOUT_EN
  logic       vt, ot, tt, lt;
  logic [7:0] pt, ht;
  samp_t      qt[$];

  pwm_capture #(.CNT_WIDTH(8), .SYNC_STAGES(2), .TIMEOUT_CYCLES(64)) dut_to (
    .ACLK(ACLK), .ARESET(ARESET), .pwm_in(pwm_in), .en(en),
    .m_valid(vt), .m_ready(m_ready), .m_period(pt), .m_high(ht),
    .m_ovf(ot), .m_timeout(tt), .lost(lt), .clr_lost(clr_lost)
  );

  always @(negedge ACLK)
    if (vt && m_ready) qt.push_back(samp_t'{32'(pt), 32'(ht), ot, tt});
`endif

  // Collect accepted samples and watch field stability under backpressure
  always @(negedge ACLK) begin
    if (m_valid && m_ready) q.push_back(samp_t'{m_period, m_high, m_ovf, m_timeout});
    if (v8 && m_ready) q8.push_back(samp_t'{32'(p8), 32'(h8), o8, t8});
    if (pv && !pr && (!m_valid || m_period != pp || m_high != ph || m_ovf != po))
      hold_viol = 1'b1;
    pv = m_valid; pr = m_ready; pp = m_period; ph = m_high; po = m_ovf;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge ACLK);
    #1;
  endtask

  task automatic pwm_cycle(input int hi, input int lo);
    pwm_in = 1'b1; tick(hi);
    pwm_in = 1'b0; tick(lo);
  endtask

  task automatic do_reset();
    ARESET = 1'b1; en = 1'b0; pwm_in = 1'b0; m_ready = 1'b0; clr_lost = 1'b0;
    tick(3);
    ARESET = 1'b0;
    tick(1);
    q.delete(); q8.delete();
`ifdef PWM_CAPTURE_TIMEOUT_EN
    qt.delete();
`endif
    hold_viol = 1'b0;
  endtask

  task automatic test_reset();
    ARESET = 1'b1; en = 1'b0; pwm_in = 1'b0; m_ready = 1'b0; clr_lost = 1'b0;
    tick(3);
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", m_valid); end
    checks++; if (m_period !== 32'd0) begin errors++; $display("FAIL reset_period got=%0d exp=0", m_period); end
    checks++; if (m_high !== 32'd0) begin errors++; $display("FAIL reset_high got=%0d exp=0", m_high); end
    checks++; if (m_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", m_ovf); end
    checks++; if (m_timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got=%b exp=0", m_timeout); end
    checks++; if (lost !== 1'b0) begin errors++; $display("FAIL reset_lost got=%b exp=0", lost); end
    ARESET = 1'b0;
    tick(1);
  endtask

  task automatic test_basic();
    int lat;
    do_reset();
    en = 1'b1; m_ready = 1'b1; tick(2);
    pwm_cycle(10, 30);
    pwm_in = 1'b1; lat = 0;
    for (int k = 1; k <= 10; k++) begin
      tick(1);
      if (m_valid && lat == 0) lat = k;
    end
    pwm_in = 1'b0; tick(30);
    pwm_cycle(10, 30);
    pwm_cycle(10, 30);
    tick(10);
    checks++; if (lat !== 4) begin errors++; $display("FAIL basic_latency got=%0d exp=4", lat); end
    checks++; if (q.size() !== 3) begin errors++; $display("FAIL basic_count got=%0d exp=3", q.size()); end
    foreach (q[i]) begin
      checks++; if (q[i].period !== 32'd40) begin errors++; $display("FAIL basic_period[%0d] got=%0d exp=40", i, q[i].period); end
      checks++; if (q[i].high !== 32'd10) begin errors++; $display("FAIL basic_high[%0d] got=%0d exp=10", i, q[i].high); end
      checks++; if (q[i].ovf !== 1'b0) begin errors++; $display("FAIL basic_ovf[%0d] got=%b exp=0", i, q[i].ovf); end
      checks++; if (q[i].tmo !== 1'b0) begin errors++; $display("FAIL basic_tmo[%0d] got=%b exp=0", i, q[i].tmo); end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    en = 1'b1; m_ready = 1'b0; tick(2);
    repeat (3) pwm_cycle(5, 15);
    pwm_in = 1'b1; tick(5);
    pwm_in = 1'b0; tick(10);
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL bp_valid got=%b exp=1", m_valid); end
    checks++; if (m_period !== 32'd20) begin errors++; $display("FAIL bp_period got=%0d exp=20", m_period); end
    checks++; if (m_high !== 32'd5) begin errors++; $display("FAIL bp_high got=%0d exp=5", m_high); end
    checks++; if (lost !== 1'b1) begin errors++; $display("FAIL bp_lost got=%b exp=1", lost); end
    checks++; if (hold_viol !== 1'b0) begin errors++; $display("FAIL bp_stable got=%b exp=0", hold_viol); end
    m_ready = 1'b1; tick(1);
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL bp_drop_valid got=%b exp=0", m_valid); end
    checks++; if (q.size() !== 1) begin errors++; $display("FAIL bp_accept_count got=%0d exp=1", q.size()); end
    if (q.size() == 1) begin
      checks++; if (q[0].period !== 32'd20) begin errors++; $display("FAIL bp_accept_period got=%0d exp=20", q[0].period); end
    end
    checks++; if (lost !== 1'b1) begin errors++; $display("FAIL bp_lost_sticky got=%b exp=1", lost); end
    clr_lost = 1'b1; tick(1); clr_lost = 1'b0;
    checks++; if (lost !== 1'b0) begin errors++; $display("FAIL bp_clr_lost got=%b exp=0", lost); end
  endtask

  task automatic test_overflow();
    do_reset();
    en = 1'b1; m_ready = 1'b1; tick(2);
    pwm_cycle(300, 10);
    pwm_cycle(20, 20);
    pwm_in = 1'b1; tick(20);
    pwm_in = 1'b0; tick(10);
    checks++; if (q8.size() !== 2) begin errors++; $display("FAIL ovf_count got=%0d exp=2", q8.size()); end
    if (q8.size() == 2) begin
      checks++; if (q8[0].period !== 32'd255) begin errors++; $display("FAIL ovf_period got=%0d exp=255", q8[0].period); end
      checks++; if (q8[0].high !== 32'd255) begin errors++; $display("FAIL ovf_high got=%0d exp=255", q8[0].high); end
      checks++; if (q8[0].ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b exp=1", q8[0].ovf); end
      checks++; if (q8[1].period !== 32'd40) begin errors++; $display("FAIL ovf_next_period got=%0d exp=40", q8[1].period); end
      checks++; if (q8[1].high !== 32'd20) begin errors++; $display("FAIL ovf_next_high got=%0d exp=20", q8[1].high); end
      checks++; if (q8[1].ovf !== 1'b0) begin errors++; $display("FAIL ovf_next_flag got=%b exp=0", q8[1].ovf); end
    end
    checks++; if (q.size() !== 2) begin errors++; $display("FAIL wide_count got=%0d exp=2", q.size()); end
    if (q.size() == 2) begin
      checks++; if (q[0].period !== 32'd310) begin errors++; $display("FAIL wide_period got=%0d exp=310", q[0].period); end
      checks++; if (q[0].high !== 32'd300) begin errors++; $display("FAIL wide_high got=%0d exp=300", q[0].high); end
      checks++; if (q[0].ovf !== 1'b0) begin errors++; $display("FAIL wide_ovf got=%b exp=0", q[0].ovf); end
    end
  endtask

  task automatic test_en_toggle();
    do_reset();
    en = 1'b1; m_ready = 1'b1; tick(2);
    pwm_in = 1'b1; tick(5);
    en = 1'b0; tick(5);
    pwm_in = 1'b0; tick(10);
    en = 1'b1; tick(2);
    pwm_cycle(10, 10);
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL en_first_rise_valid got=%b exp=0", m_valid); end
    checks++; if (q.size() !== 0) begin errors++; $display("FAIL en_no_sample got=%0d exp=0", q.size()); end
    m_ready = 1'b0;
    pwm_cycle(10, 10);
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL en_second_rise_valid got=%b exp=1", m_valid); end
    checks++; if (m_period !== 32'd20) begin errors++; $display("FAIL en_period got=%0d exp=20", m_period); end
    checks++; if (m_high !== 32'd10) begin errors++; $display("FAIL en_high got=%0d exp=10", m_high); end
    ARESET = 1'b1; tick(1);
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got=%b exp=0", m_valid); end
    checks++; if (m_period !== 32'd0) begin errors++; $display("FAIL rst_mid_period got=%0d exp=0", m_period); end
    checks++; if (m_high !== 32'd0) begin errors++; $display("FAIL rst_mid_high got=%0d exp=0", m_high); end
    checks++; if (lost !== 1'b0) begin errors++; $display("FAIL rst_mid_lost got=%b exp=0", lost); end
    ARESET = 1'b0; tick(1);
  endtask

  // Timer model: counter 0..PERIOD, output high while counter < DUTY
  task automatic test_closed_loop();
    do_reset();
    en = 1'b1; m_ready = 1'b1; tick(2);
    for (int w = 0; w < 9; w++)
      for (int c = 0; c <= 32'h63; c++) begin
        pwm_in = (c < 32'h20);
        tick(1);
      end
    pwm_in = 1'b0; tick(10);
    checks++; if (q.size() !== 8) begin errors++; $display("FAIL loop_count got=%0d exp=8", q.size()); end
    foreach (q[i]) begin
      checks++; if (q[i].period !== 32'd100) begin errors++; $display("FAIL loop_period[%0d] got=%0d exp=100", i, q[i].period); end
      checks++; if (q[i].high !== 32'd32) begin errors++; $display("FAIL loop_high[%0d] got=%0d exp=32", i, q[i].high); end
    end
  endtask

`ifdef PWM_CAPTURE_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    en = 1'b1; m_ready = 1'b1; tick(2);
    pwm_cycle(10, 10);
    pwm_in = 1'b1; tick(300);
    checks++; if (qt.size() !== 2) begin errors++; $display("FAIL to_count got=%0d exp=2", qt.size()); end
    if (qt.size() == 2) begin
      checks++; if (qt[1].tmo !== 1'b1) begin errors++; $display("FAIL to_flag got=%b exp=1", qt[1].tmo); end
      checks++; if (qt[1].period !== 32'd0) begin errors++; $display("FAIL to_period got=%0d exp=0", qt[1].period); end
      checks++; if (qt[1].high !== 32'd255) begin errors++; $display("FAIL to_high got=%0d exp=255", qt[1].high); end
    end
    pwm_in = 1'b0; tick(100);
    checks++; if (qt.size() !== 3) begin errors++; $display("FAIL to_rearm_count got=%0d exp=3", qt.size()); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_overflow();
    test_en_toggle();
    test_closed_loop();
`ifdef PWM_CAPTURE_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
